uirq_ctrl: RTL and testbench

- User-level interrupt controller feeding the CSR trap path of the single-cycle core.
- Edge-detects NSRC external sources into a pending register and masks them with an enable register.
- Selects the lowest-numbered enabled pending source and issues a one-cycle interrupt request with cause code.
- Blocks further requests until the handler returns via uret. No nesting.

---
 rtl/uirq_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_uirq_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uirq_ctrl.sv
// ----------------------------------------------------------------------------
// uirq_ctrl -- user-level interrupt controller for the CSR trap path.
//
// Rising edges on the external lines set bits in a pending register. The
// pending bits are masked by an enable register. When the core is idle, the
// lowest-numbered enabled pending source is selected. A one-cycle interrupt
// pulse is then issued, together with its cause code. No further request is
// made until the handler returns with uret. Interrupts do not nest.
//
// Ports
//   clk        system clock, every state update happens on its rising edge
//   rstn       synchronous active-low reset
//   irq_src    external interrupt lines, already synchronous to clk
//   uie        global user interrupt enable (ustatus bit 0)
//   exception  synchronous exception this cycle; suppresses a request
//   uret       handler return this cycle
//   we         register write strobe
//   addr       register select: 0 enable, 1 pending (W1C), 2 status, 3 zero
//   din        write data
//   dout       combinational read data (state before the current edge)
//   interrupt  registered one-cycle interrupt request
//   icause     registered cause for the pulse, held until the next request
// ----------------------------------------------------------------------------
module uirq_ctrl #(
    parameter int NSRC       = 4,
    parameter int CAUSE_BASE = 16
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [NSRC-1:0] irq_src,
    input  logic            uie,
    input  logic            exception,
    input  logic            uret,
    input  logic            we,
    input  logic [1:0]      addr,
    input  logic [31:0]     din,
    output logic [31:0]     dout,
    output logic            interrupt,
    output logic [31:0]     icause
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    localparam logic [1:0] ADDR_ENABLE  = 2'd0;
    localparam logic [1:0] ADDR_PENDING = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          state_q,     state_d;
    logic [NSRC-1:0] pending_q,   pending_d;
    logic [NSRC-1:0] enable_q,    enable_d;
    logic [NSRC-1:0] prev_src_q,  prev_src_d;
    logic [3:0]      active_id_q, active_id_d;
    logic            interrupt_q, interrupt_d;
    logic [31:0]     icause_q,    icause_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [NSRC-1:0] src_rise;      // rising edge on each source this cycle
    logic [NSRC-1:0] cand;          // enabled and pending
    logic [NSRC:0]   lower_hit;     // lower_hit[i]: some cand below index i
    logic [NSRC-1:0] sel_onehot;    // lowest candidate, one-hot
    logic [3:0]      sel_id;        // index of that candidate
    logic            req;           // request fires at this edge
    logic [NSRC-1:0] w1c_mask;      // pending bits cleared by a register write
    logic [NSRC-1:0] svc_mask;      // pending bit consumed by the request
    logic            unused_din;

    // Upper data bits are never stored anywhere.
    assign unused_din = ^din[31:NSRC];

    assign src_rise = irq_src & ~prev_src_q;
    assign cand     = pending_q & enable_q;

    // Ripple priority chain: the first candidate from bit 0 upward wins.
    assign lower_hit[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_prio
            assign sel_onehot[gi]  = cand[gi] & ~lower_hit[gi];
            assign lower_hit[gi+1] = lower_hit[gi] | cand[gi];
        end
    endgenerate

    always_comb begin
        sel_id = 4'd0;
        for (int i = 0; i < NSRC; i++) begin
            if (sel_onehot[i]) begin
                sel_id = 4'(i);
            end
        end
    end

    // lower_hit[NSRC] is the OR of every candidate.
    assign req = (state_q == ST_IDLE) & uie & ~exception & lower_hit[NSRC];

    assign w1c_mask = (we && addr == ADDR_PENDING) ? din[NSRC-1:0] : '0;
    assign svc_mask = req ? sel_onehot : '0;

    // A new edge wins over both a software clear and the service clear.
    // This lets a source that fires again while it is being serviced be
    // taken again after uret.
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_pend
            assign pending_d[gi] = src_rise[gi]
                                 | (pending_q[gi] & ~w1c_mask[gi] & ~svc_mask[gi]);
        end
    endgenerate

    assign prev_src_d = irq_src;
    assign enable_d   = (we && addr == ADDR_ENABLE) ? din[NSRC-1:0] : enable_q;

    // ------------------------------------------------------------------
    // Handler FSM: next state and registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        active_id_d = active_id_q;
        interrupt_d = 1'b0;
        icause_d    = icause_q;

        unique case (state_q)
            ST_IDLE: begin
                // uret while idle has no effect.
                if (req) begin
                    interrupt_d = 1'b1;
                    icause_d    = 32'h8000_0000
                                | (32'(CAUSE_BASE) + {28'd0, sel_id});
                    active_id_d = sel_id;
                    state_d     = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                // Leaving ACTIVE only reaches IDLE at this edge, so the next
                // request can fire one edge later at the earliest.
                if (uret) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            enable_q    <= '0;
            // Lines already high when reset is released must not look like
            // edges, so the previous-value register tracks the lines.
            prev_src_q  <= irq_src;
            active_id_q <= 4'd0;
            interrupt_q <= 1'b0;
            icause_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            enable_q    <= enable_d;
            prev_src_q  <= prev_src_d;
            active_id_q <= active_id_d;
            interrupt_q <= interrupt_d;
            icause_q    <= icause_d;
        end
    end

    // ------------------------------------------------------------------
    // Read mux and outputs
    // ------------------------------------------------------------------
    always_comb begin
        dout = 32'd0;
        unique case (addr)
            ADDR_ENABLE:  dout = {{(32-NSRC){1'b0}}, enable_q};
            ADDR_PENDING: dout = {{(32-NSRC){1'b0}}, pending_q};
            ADDR_STATUS:  dout = {(state_q == ST_ACTIVE), 27'd0, active_id_q};
            default:      dout = 32'd0;
        endcase
    end

    assign interrupt = interrupt_q;
    assign icause    = icause_q;

endmodule

// File: tb/tb_uirq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_uirq_ctrl -- self-checking bench for uirq_ctrl (NSRC=4, CAUSE_BASE=16).
// A behavioural reference model is compared against the DUT on every cycle.
// A set of directed, hand-computed checks pins the expected behaviour.
// ----------------------------------------------------------------------------
module tb_uirq_ctrl;

    localparam int NSRC       = 4;
    localparam int CAUSE_BASE = 16;

    logic            clk;
    logic            rstn;
    logic [NSRC-1:0] irq_src;
    logic            uie;
    logic            exception;
    logic            uret;
    logic            we;
    logic [1:0]      addr;
    logic [31:0]     din;
    logic [31:0]     dout;
    logic            interrupt;
    logic [31:0]     icause;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    uirq_ctrl #(.NSRC(NSRC), .CAUSE_BASE(CAUSE_BASE)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .irq_src   (irq_src),
        .uie       (uie),
        .exception (exception),
        .uret      (uret),
        .we        (we),
        .addr      (addr),
        .din       (din),
        .dout      (dout),
        .interrupt (interrupt),
        .icause    (icause)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // Reference model: pending/enable as bit sets, handler busy as a flag
    // ------------------------------------------------------------------
    bit [NSRC-1:0] m_pend, m_en, m_prev;
    bit            m_active;
    int            m_aid;
    bit            m_int;
    bit [31:0]     m_icause;

    always @(posedge clk) begin
        bit [NSRC-1:0] np;
        int            id;
        if (!rstn) begin
            m_pend   <= '0;
            m_en     <= '0;
            m_prev   <= irq_src;
            m_active <= 1'b0;
            m_aid    <= 0;
            m_int    <= 1'b0;
            m_icause <= 32'd0;
        end else begin
            id = -1;
            if (!m_active && uie && !exception) begin
                for (int i = 0; i < NSRC; i++) begin
                    if (id < 0 && m_pend[i] && m_en[i]) id = i;
                end
            end
            np = m_pend;
            for (int i = 0; i < NSRC; i++) begin
                if (we && addr == 2'd1 && din[i]) np[i] = 1'b0;
                if (id == i) np[i] = 1'b0;
                if (irq_src[i] && !m_prev[i]) np[i] = 1'b1;
            end
            m_pend <= np;
            m_prev <= irq_src;
            if (we && addr == 2'd0) m_en <= din[NSRC-1:0];
            m_int <= (id >= 0);
            if (id >= 0) begin
                m_icause <= 32'h8000_0000 + 32'(CAUSE_BASE + id);
                m_active <= 1'b1;
                m_aid    <= id;
            end else if (m_active && uret) begin
                m_active <= 1'b0;
            end
        end
    end

    function automatic bit [31:0] model_dout(input bit [1:0] a);
        case (a)
            2'd0:    return 32'(m_en);
            2'd1:    return 32'(m_pend);
            2'd2:    return (m_active ? 32'h8000_0000 : 32'd0) + 32'(m_aid);
            default: return 32'd0;
        endcase
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Directed check with one transcript line per check.
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp(name, act, exp);
        $display("[%0t] %-22s got %08h expected %08h", $time, name, act, exp);
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            cmp("model.interrupt", {31'd0, interrupt}, {31'd0, m_int});
            cmp("model.icause", icause, m_icause);
            cmp("model.dout", dout, model_dout(addr));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = dout;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; din = d;
        tick();
        we = 1'b0; din = 32'd0;
    endtask

    logic [31:0] v;
    int          pulses;

    initial begin
        rstn = 1'b0; irq_src = '0; uie = 1'b0; exception = 1'b0;
        uret = 1'b0; we = 1'b0; addr = 2'd0; din = 32'd0;
        tick();
        chk_on = 1'b1;
        tick();
        tick();
        chk("reset.interrupt", {31'd0, interrupt}, 32'd0);
        chk("reset.icause", icause, 32'd0);
        rd(2'd2, v); chk("reset.status", v, 32'd0);
        rstn = 1'b1;

        // ---- 1. basic path ----
        wr(2'd0, 32'h2);
        uie = 1'b1;
        irq_src = 4'b0010;
        tick();                                   // edge captured
        chk("t1.no_pulse_yet", {31'd0, interrupt}, 32'd0);
        rd(2'd1, v); chk("t1.pending_set", v, 32'h2);
        irq_src = 4'b0000;
        tick();                                   // request registered
        chk("t1.pulse", {31'd0, interrupt}, 32'd1);
        chk("t1.icause", icause, 32'h8000_0011);
        rd(2'd2, v); chk("t1.status", v, 32'h8000_0001);
        rd(2'd1, v); chk("t1.pending_clr", v, 32'd0);
        tick();
        chk("t1.pulse_end", {31'd0, interrupt}, 32'd0);
        chk("t1.icause_hold", icause, 32'h8000_0011);
        uret = 1'b1; tick(); uret = 1'b0;

        // ---- 2. priority and blocking ----
        wr(2'd0, 32'hF);
        irq_src = 4'b1010;
        tick();
        irq_src = 4'b0000;
        tick();
        chk("t2.first_pulse", {31'd0, interrupt}, 32'd1);
        chk("t2.first_cause", icause, 32'h8000_0011);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2.blocked", {31'd0, interrupt}, 32'd0);
        end
        uret = 1'b1;
        tick();
        uret = 1'b0;
        chk("t2.uret_edge", {31'd0, interrupt}, 32'd0);
        tick();
        chk("t2.second_pulse", {31'd0, interrupt}, 32'd1);
        chk("t2.second_cause", icause, 32'h8000_0013);
        wr(2'd2, 32'hFFFF_FFFF);
        rd(2'd2, v); chk("t4.status_ro", v, 32'h8000_0003);
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd3, v); chk("t4.addr3_zero", v, 32'd0);
        rd(2'd0, v); chk("t2.enable_rd", v, 32'hF);
        uret = 1'b1; tick(); uret = 1'b0;

        // ---- 3. masking and suppression ----
        uie = 1'b0;
        irq_src = 4'b0001;
        tick();
        irq_src = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3.uie_masked", {31'd0, interrupt}, 32'd0);
        end
        rd(2'd1, v); chk("t3.pending_kept", v, 32'h1);
        uie = 1'b1; exception = 1'b1;
        tick();
        chk("t3.exc_suppress", {31'd0, interrupt}, 32'd0);
        exception = 1'b0;
        tick();
        chk("t3.retry_pulse", {31'd0, interrupt}, 32'd1);
        chk("t3.retry_cause", icause, 32'h8000_0010);
        uret = 1'b1; tick(); uret = 1'b0;

        // ---- 4. register races ----
        uie = 1'b0;
        irq_src = 4'b0100;
        wr(2'd1, 32'h4);                         // W1C and edge together
        rd(2'd1, v); chk("t4.edge_wins", v, 32'h4);
        wr(2'd1, 32'h4);                         // W1C alone
        rd(2'd1, v); chk("t4.w1c", v, 32'd0);
        irq_src = 4'b0000;
        tick();

        // ---- 6. level hold ----
        uie = 1'b1;
        irq_src = 4'b0100;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            uret = (i == 5);
            tick();
            if (interrupt) pulses++;
        end
        uret = 1'b0;
        chk("t6.one_pulse", 32'(pulses), 32'd1);
        rd(2'd1, v); chk("t6.pending_clr", v, 32'd0);
        irq_src = 4'b0000;
        tick();

        // ---- 5. reset cases ----
        rstn = 1'b0;
        irq_src = 4'b0001;
        tick(); tick();
        rstn = 1'b1;
        tick(); tick();
        rd(2'd1, v); chk("t5.no_edge_at_rel", v, 32'd0);
        chk("t5.no_pulse", {31'd0, interrupt}, 32'd0);
        rd(2'd0, v); chk("t5.enable_reset", v, 32'd0);
        wr(2'd0, 32'h1);
        irq_src = 4'b0000; tick();
        irq_src = 4'b0001; tick();
        tick();
        chk("t5.pulse", {31'd0, interrupt}, 32'd1);
        rd(2'd2, v); chk("t5.active", v, 32'h8000_0000);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        rd(2'd2, v); chk("t5.status_reset", v, 32'd0);
        chk("t5.icause_reset", icause, 32'd0);
        wr(2'd0, 32'h1);
        irq_src = 4'b0000; tick();
        irq_src = 4'b0001; tick();
        tick();
        chk("t5.no_uret_pulse", {31'd0, interrupt}, 32'd1);
        chk("t5.no_uret_cause", icause, 32'h8000_0010);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
